// File: rtl/mem_pkg.sv
// Shared types for the memory master: access size encoding, FSM states,
// and small helpers for alignment checks on the low address bits.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_e;

  // The unused size code 11 behaves as a word access.
  function automatic mem_size_e norm_size(logic [1:0] s);
    return (s == 2'b11) ? MEM_WORD : mem_size_e'(s);
  endfunction

  function automatic logic misaligned(mem_size_e s, logic [1:0] off);
    case (s)
      MEM_HALF: return off[0];
      MEM_WORD: return (off != 2'b00);
      default:  return 1'b0;
    endcase
  endfunction

  // Clear the low bits that break natural alignment for this size.
  function automatic logic [1:0] force_align(mem_size_e s, logic [1:0] off);
    case (s)
      MEM_HALF: return {off[1], 1'b0};
      MEM_WORD: return 2'b00;
      default:  return off;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load lane select + sign/zero extend, and
// store lane merge into a read word.
// Ports: size_i, uns_i, off_i, rdata_i, wdata_i in; load_o, merge_o out.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  bytev;
  logic [15:0] halfv;

  always_comb begin
    bytev   = rdata_i[{off_i, 3'b000} +: 8];
    halfv   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o  = rdata_i;
    merge_o = wdata_i;
    case (size_i)
      MEM_BYTE: begin
        load_o  = {{24{~uns_i & bytev[7]}}, bytev};
        merge_o = rdata_i;
        merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      MEM_HALF: begin
        load_o  = {{16{~uns_i & halfv[15]}}, halfv};
        merge_o = off_i[1] ? {wdata_i[15:0], rdata_i[15:0]}
                           : {rdata_i[31:16], wdata_i[15:0]};
      end
      default: begin
        load_o  = rdata_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_master.sv
// Single-request load/store master onto a word memory with combinational
// read and clocked write; sub-word stores do read-modify-write.
// Ports: clk, reset; req_* request handshake; resp_* completion pulse;
// mem_* word memory side.
// Config: MEM_MASTER_MISALIGN_TRAP_EN traps misaligned half/word accesses
// (resp_err, no memory access); otherwise low address bits are cleared.
module mem_master
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_write_enab,
  output logic [31:0] mem_write_data
);

  state_e      state_q;
  logic        ready_q, valid_q, err_q, we_q;
  logic [31:0] rdata_q, addr_q, wdata_q;
  logic        write_q, uns_q;
  mem_size_e   size_q;
  logic [1:0]  off_q;
  logic [31:0] reqw_q;

  mem_size_e   sz_d;
  logic [1:0]  off_d;
  logic        trap_d;
  logic [31:0] load_w, merge_w;

  always_comb begin
    sz_d   = norm_size(req_size);
    off_d  = req_addr[1:0];
    trap_d = 1'b0;
`ifdef MEM_MASTER_MISALIGN_TRAP_EN
    trap_d = misaligned(sz_d, off_d);
`else
    off_d  = force_align(sz_d, off_d);
`endif
  end

  mem_lane_align u_lane (
    .size_i  (size_q),
    .uns_i   (uns_q),
    .off_i   (off_q),
    .rdata_i (mem_rdata),
    .wdata_i (reqw_q),
    .load_o  (load_w),
    .merge_o (merge_w)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= MEM_BYTE;
      off_q   <= 2'b00;
      reqw_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            write_q <= req_write;
            uns_q   <= req_unsigned;
            size_q  <= sz_d;
            off_q   <= off_d;
            reqw_q  <= req_wdata;
            addr_q  <= {req_addr[31:2], 2'b00};
            if (trap_d) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (req_write && sz_d == MEM_WORD) begin
              state_q <= WRITE;
              we_q    <= 1'b1;
              wdata_q <= req_wdata;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (write_q) begin
            state_q <= WRITE;
            we_q    <= 1'b1;
            wdata_q <= merge_w;
          end else begin
            state_q <= DONE;
            valid_q <= 1'b1;
            rdata_q <= load_w;
          end
        end
        WRITE: begin
          we_q    <= 1'b0;
          state_q <= DONE;
          valid_q <= 1'b1;
          rdata_q <= '0;
        end
        DONE: begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready      = ready_q;
  assign resp_valid     = valid_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_addr       = addr_q;
  assign mem_write_enab = we_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: word RAM model, load/store scenarios,
// back-to-back, misalignment and reset abort.
module tb_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_rdata, mem_write_data;
  logic        mem_write_enab;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wes;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ram [0:15];
  logic        ram_init;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
      ram[1] <= 32'h8899AABB;
      ram[2] <= 32'h11223344;
    end else if (mem_write_enab) begin
      ram[mem_addr[5:2]] <= mem_write_data;
    end
  end

  assign mem_rdata = ram[mem_addr[5:2]];

  mem_master dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_write_enab (mem_write_enab),
    .mem_write_data (mem_write_data)
  );

  // Present a request (called at a negedge), wait for accept, then count
  // negedges until resp_valid; compare against the scoreboard entry.
  task automatic do_req(input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat,
                        input int exp_wes, input int exp_wait,
                        input string nm);
    exp_t e, g;
    int   waits, lat, wes;
    logic rdy, acc, ok, rdy_bad;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_lat;
    e.wes   = exp_wes;
    sb.push_back(e);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    acc = 1'b0;
    waits = 0;
    for (int k = 0; k < 10; k++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    #1 req_valid = 1'b0;
    lat = 0;
    wes = 0;
    ok = 1'b0;
    rdy_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (mem_write_enab) wes++;
      if (req_ready) rdy_bad = 1'b1;
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    g = sb.pop_front();
    tot_cnt++;
    if (!acc || !ok)
      $display("FAIL %s handshake: accepted=%0b responded=%0b required 1/1",
               nm, acc, ok);
    else pass_cnt++;
    tot_cnt++;
    if (resp_rdata !== g.rdata)
      $display("FAIL %s rdata: got %h required %h", nm, resp_rdata, g.rdata);
    else pass_cnt++;
    tot_cnt++;
    if (resp_err !== g.err)
      $display("FAIL %s err: got %b required %b", nm, resp_err, g.err);
    else pass_cnt++;
    tot_cnt++;
    if (lat != g.lat)
      $display("FAIL %s latency: got %0d required %0d", nm, lat, g.lat);
    else pass_cnt++;
    tot_cnt++;
    if (wes != g.wes)
      $display("FAIL %s write pulses: got %0d required %0d", nm, wes, g.wes);
    else pass_cnt++;
    tot_cnt++;
    if (rdy_bad)
      $display("FAIL %s req_ready: got 1 while busy required 0", nm);
    else pass_cnt++;
    if (exp_wait >= 0) begin
      tot_cnt++;
      if (waits != exp_wait)
        $display("FAIL %s accept wait: got %0d required %0d",
                 nm, waits, exp_wait);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ram_init = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    #1;
    tot_cnt++;
    if ({req_ready, resp_valid, resp_err, mem_write_enab} !== 4'b1000)
      $display("FAIL reset flags: got %b required 1000",
               {req_ready, resp_valid, resp_err, mem_write_enab});
    else pass_cnt++;
    tot_cnt++;
    if (resp_rdata !== 32'h0)
      $display("FAIL reset rdata: got %h required 0", resp_rdata);
    else pass_cnt++;
    tot_cnt++;
    if (mem_addr !== 32'h0 || mem_write_data !== 32'h0)
      $display("FAIL reset mem: got addr %h data %h required 0/0",
               mem_addr, mem_write_data);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    do_req(0, 2'b00, 0, 32'h5, 0, 32'hFFFFFFAA, 0, 2, 0, -1, "lb5");
    do_req(0, 2'b00, 1, 32'h5, 0, 32'h000000AA, 0, 2, 0, -1, "lbu5");
    do_req(0, 2'b00, 0, 32'h7, 0, 32'hFFFFFF88, 0, 2, 0, -1, "lb7");
    do_req(0, 2'b00, 1, 32'h4, 0, 32'h000000BB, 0, 2, 0, -1, "lbu4");
    do_req(0, 2'b01, 0, 32'h6, 0, 32'hFFFF8899, 0, 2, 0, -1, "lh6");
    do_req(0, 2'b01, 1, 32'h4, 0, 32'h0000AABB, 0, 2, 0, -1, "lhu4");
    do_req(0, 2'b10, 0, 32'h4, 0, 32'h8899AABB, 0, 2, 0, -1, "lw4");
    do_req(0, 2'b11, 0, 32'h4, 0, 32'h8899AABB, 0, 2, 0, -1, "lsz11");
  endtask

  task automatic test_subword_store();
    do_req(1, 2'b01, 0, 32'hA, 32'h0000BEEF, 0, 0, 3, 1, -1, "sha");
    tot_cnt++;
    if (ram[2] !== 32'hBEEF3344)
      $display("FAIL sh ram: got %h required BEEF3344", ram[2]);
    else pass_cnt++;
    do_req(1, 2'b00, 0, 32'h8, 32'hFFFFFF55, 0, 0, 3, 1, -1, "sb8");
    tot_cnt++;
    if (ram[2] !== 32'hBEEF3355)
      $display("FAIL sb ram: got %h required BEEF3355", ram[2]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_req(1, 2'b10, 0, 32'hC, 32'hDEADBEEF, 0, 0, 2, 1, 1, "swc");
    tot_cnt++;
    if (ram[3] !== 32'hDEADBEEF)
      $display("FAIL sw ram: got %h required DEADBEEF", ram[3]);
    else pass_cnt++;
    do_req(0, 2'b10, 0, 32'hC, 0, 32'hDEADBEEF, 0, 2, 0, 1, "lwc");
  endtask

  task automatic test_misalign();
`ifdef MEM_MASTER_MISALIGN_TRAP_EN
    do_req(0, 2'b10, 0, 32'h6, 0, 32'h0, 1, 1, 0, -1, "lw6");
    do_req(1, 2'b01, 0, 32'h9, 32'h1234, 32'h0, 1, 1, 0, -1, "sh9");
    tot_cnt++;
    if (ram[2] !== 32'hBEEF3355)
      $display("FAIL sh9 ram: got %h required BEEF3355", ram[2]);
    else pass_cnt++;
`else
    do_req(0, 2'b10, 0, 32'h6, 0, 32'h8899AABB, 0, 2, 0, -1, "lw6");
    do_req(1, 2'b01, 0, 32'h9, 32'h1234, 32'h0, 0, 3, 1, -1, "sh9");
    tot_cnt++;
    if (ram[2] !== 32'hBEEF1234)
      $display("FAIL sh9 ram: got %h required BEEF1234", ram[2]);
    else pass_cnt++;
`endif
    tot_cnt++;
    if (mem_addr !== 32'h8)
      $display("FAIL hold addr: got %h required 00000008", mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic saw_we, saw_valid;
    @(negedge clk);
    req_write = 1'b1;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'h4;
    req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    tot_cnt++;
    if (req_ready !== 1'b1 || mem_write_enab !== 1'b0)
      $display("FAIL abort immediate: got ready %b we %b required 1/0",
               req_ready, mem_write_enab);
    else pass_cnt++;
    saw_we = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b0;
      if (mem_write_enab) saw_we = 1'b1;
      if (resp_valid) saw_valid = 1'b1;
    end
    tot_cnt++;
    if (saw_we || saw_valid)
      $display("FAIL abort activity: got we %b valid %b required 0/0",
               saw_we, saw_valid);
    else pass_cnt++;
    tot_cnt++;
    if (ram[1] !== 32'h8899AABB)
      $display("FAIL abort ram: got %h required 8899AABB", ram[1]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_subword_store();
    test_back_to_back();
    test_misalign();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
